// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline controller: default parameters and FSM state encoding.
package pipe_pkg;

    localparam int DEF_NSTAGE   = 5;
    localparam int DEF_EXEC_IDX = 2;
    localparam int DEF_XLEN     = 32;
    localparam int DEF_CNT_W    = 32;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_FLUSH_WAIT = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// In-order pipeline controller: stage enables/flushes, fetch PC, redirect FSM and perf counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int              NSTAGE   = DEF_NSTAGE,
    parameter int              EXEC_IDX = DEF_EXEC_IDX,
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stage_fin,
    input  logic              lwstall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic [XLEN-1:0]   pred_pc,
    input  logic              cnt_clr,
    output logic [XLEN-1:0]   pc,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] stage_flush,
    output logic              flush_pending,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redir_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic              w_all_fin;
    logic              w_back_en;
    logic              w_front_en;
    logic [NSTAGE-1:0] w_en;
    logic [NSTAGE-1:0] w_flush;

    // Back end (past EXEC_IDX) drains whenever everything downstream is done;
    // w_back_en is the enable of the register right after the exec stage.
    always_comb begin
        w_all_fin  = &stage_fin;
        w_back_en  = &stage_fin[NSTAGE-1:EXEC_IDX];
        w_front_en = w_all_fin && !lwstall && !redirect_valid && (r_state == ST_RUN);
        w_en       = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i <= EXEC_IDX) begin
                w_en[i] = w_front_en;
            end else begin
                w_en[i] = 1'b1;
                for (int j = i - 1; j < NSTAGE; j++) begin
                    w_en[i] = w_en[i] & stage_fin[j];
                end
            end
        end
    end

    always_comb begin
        w_flush = '0;
        for (int i = 1; i < EXEC_IDX; i++) begin
            w_flush[i] = redirect_valid;
        end
        w_flush[EXEC_IDX] = w_back_en &&
                            (lwstall || redirect_valid || (r_state == ST_FLUSH_WAIT));
        if (rst) begin
            w_flush = {{(NSTAGE-1){1'b1}}, 1'b0};
        end
    end

    // Stay in FLUSH_WAIT until the exec stage can hand a bubble downstream.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:        if (redirect_valid && !w_back_en) w_state_next = ST_FLUSH_WAIT;
            ST_FLUSH_WAIT: if (w_back_en) w_state_next = ST_RUN;
            default:       w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_en[0]) begin
                r_pc <= pred_pc;
            end
        end
    end

    assign pc            = r_pc;
    assign stage_en      = w_en;
    assign stage_flush   = w_flush;
    assign flush_pending = (r_state == ST_FLUSH_WAIT);

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .count (cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (!w_en[0]),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (redirect_valid),
        .count (redir_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: stimulus pushes expected values tagged with a cycle, a negedge monitor checks them.
module tb_pipeline_ctrl;

    localparam int K_PC     = 0;
    localparam int K_EN     = 1;
    localparam int K_FLUSH  = 2;
    localparam int K_FP     = 3;
    localparam int K_CYC    = 4;
    localparam int K_STALL  = 5;
    localparam int K_REDIR  = 6;
    localparam int K_STALL4 = 7;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stage_fin;
    logic        lwstall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pred_pc;
    logic        cnt_clr;

    logic [31:0] pc;
    logic [4:0]  stage_en;
    logic [4:0]  stage_flush;
    logic        flush_pending;
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;

    logic [31:0] pc4;
    logic [4:0]  stage_en4;
    logic [4:0]  stage_flush4;
    logic        flush_pending4;
    logic [3:0]  cyc_cnt4;
    logic [3:0]  stall_cnt4;
    logic [3:0]  redir_cnt4;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pipeline_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .stage_fin      (stage_fin),
        .lwstall        (lwstall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_pc        (pred_pc),
        .cnt_clr        (cnt_clr),
        .pc             (pc),
        .stage_en       (stage_en),
        .stage_flush    (stage_flush),
        .flush_pending  (flush_pending),
        .cyc_cnt        (cyc_cnt),
        .stall_cnt      (stall_cnt),
        .redir_cnt      (redir_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .stage_fin      (stage_fin),
        .lwstall        (lwstall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_pc        (pred_pc),
        .cnt_clr        (cnt_clr),
        .pc             (pc4),
        .stage_en       (stage_en4),
        .stage_flush    (stage_flush4),
        .flush_pending  (flush_pending4),
        .cyc_cnt        (cyc_cnt4),
        .stall_cnt      (stall_cnt4),
        .redir_cnt      (redir_cnt4)
    );

    // Sequential fetch: predictor always guesses pc+4.
    assign pred_pc = pc + 32'd4;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] sample(input int kind);
        case (kind)
            K_PC:     return 64'(pc);
            K_EN:     return 64'(stage_en);
            K_FLUSH:  return 64'(stage_flush);
            K_FP:     return 64'(flush_pending);
            K_CYC:    return 64'(cyc_cnt);
            K_STALL:  return 64'(stall_cnt);
            K_REDIR:  return 64'(redir_cnt);
            K_STALL4: return 64'(stall_cnt4);
            default:  return '1;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [63:0] act;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                act    = sample(sb[k].kind);
                checks = checks + 1;
                if (act !== sb[k].val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h",
                             sb[k].name, cyc, act, sb[k].val);
                end
                sb.delete(k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input logic [63:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_next(input int kind, input logic [63:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        rst            = 1'b1;
        stage_fin      = 5'h1f;
        lwstall        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cnt_clr        = 1'b0;

        tick();
        expect_now(K_FLUSH, 64'h1e, "rst_flush");
        tick();
        expect_now(K_PC, 64'h0, "rst_pc");
        expect_now(K_CYC, 64'h0, "rst_cyc");
        expect_now(K_STALL, 64'h0, "rst_stall");
        expect_now(K_REDIR, 64'h0, "rst_redir");
        expect_now(K_FP, 64'h0, "rst_fp");
        rst = 1'b0;

        // Ten free-running cycles from reset.
        repeat (9) tick();
        expect_next(K_PC, 64'h28, "run10_pc");
        expect_next(K_CYC, 64'd10, "run10_cyc");
        expect_next(K_STALL, 64'd0, "run10_stall");
        tick();

        // Load-use stall: front frozen, bubble into exec, back end drains.
        lwstall = 1'b1;
        expect_now(K_EN, 64'h18, "lw_en");
        expect_now(K_FLUSH, 64'h04, "lw_flush");
        expect_next(K_PC, 64'h28, "lw_pc_hold");
        expect_next(K_STALL, 64'd1, "lw_stall");
        tick();
        lwstall = 1'b0;

        // Redirect with everything finished: immediate flush, no FLUSH_WAIT.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        expect_now(K_FLUSH, 64'h06, "redir_flush");
        expect_now(K_EN, 64'h18, "redir_en");
        expect_next(K_PC, 64'h100, "redir_pc");
        expect_next(K_REDIR, 64'd1, "redir_cnt");
        expect_next(K_FP, 64'h0, "redir_fp");
        tick();
        redirect_valid = 1'b0;

        // Redirect while stage 3 is busy for three cycles.
        stage_fin      = 5'b10111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h180;
        expect_now(K_FLUSH, 64'h02, "fw_c0_flush");
        expect_now(K_EN, 64'h00, "fw_c0_en");
        expect_next(K_PC, 64'h180, "fw_pc");
        expect_next(K_FP, 64'h1, "fw_enter");
        tick();
        redirect_valid = 1'b0;
        expect_now(K_FLUSH, 64'h00, "fw_c1_flush");
        expect_now(K_EN, 64'h00, "fw_c1_en");
        tick();
        expect_now(K_FLUSH, 64'h00, "fw_c2_flush");
        expect_now(K_FP, 64'h1, "fw_c2_fp");
        tick();
        stage_fin = 5'h1f;
        expect_now(K_FLUSH, 64'h04, "fw_exit_flush");
        expect_now(K_EN, 64'h18, "fw_exit_en");
        expect_now(K_FP, 64'h1, "fw_exit_fp");
        expect_next(K_FP, 64'h0, "fw_back_run");
        expect_next(K_STALL, 64'd6, "fw_stall");
        tick();
        expect_now(K_EN, 64'h1f, "resume_en");
        expect_now(K_FLUSH, 64'h00, "resume_flush");
        expect_now(K_PC, 64'h180, "resume_pc");
        expect_next(K_PC, 64'h184, "resume_pc_next");
        tick();

        // Two redirects inside one FLUSH_WAIT; newest target wins.
        stage_fin      = 5'b10111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        expect_next(K_PC, 64'h200, "dbl_pc1");
        expect_next(K_FP, 64'h1, "dbl_fp1");
        tick();
        redirect_valid = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        expect_now(K_FLUSH, 64'h02, "dbl_flush2");
        expect_next(K_PC, 64'h300, "dbl_pc2");
        expect_next(K_FP, 64'h1, "dbl_fp2");
        expect_next(K_REDIR, 64'd4, "dbl_redir");
        tick();
        redirect_valid = 1'b0;
        stage_fin      = 5'h1f;
        expect_now(K_FLUSH, 64'h04, "dbl_exit_flush");
        tick();
        expect_now(K_PC, 64'h300, "dbl_pc_final");
        expect_now(K_FP, 64'h0, "dbl_fp_final");
        expect_now(K_STALL, 64'd10, "dbl_stall");
        expect_now(K_STALL4, 64'd10, "dbl_stall4");
        checks = checks + 1;
        if (pc !== 32'h300) begin
            errors = errors + 1;
            $display("FAIL dbl_pc_direct got=0x%0h want=0x300", pc);
        end
        checks = checks + 1;
        if (flush_pending !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL dbl_fp_direct got=%0b want=0", flush_pending);
        end

        // Twenty stall cycles: the 4-bit counter must stick at 0xF.
        lwstall = 1'b1;
        repeat (20) tick();
        lwstall = 1'b0;
        expect_now(K_STALL4, 64'hf, "sat_stall4");
        expect_now(K_STALL, 64'd30, "sat_stall");
        checks = checks + 1;
        if (stall_cnt4 !== 4'hf) begin
            errors = errors + 1;
            $display("FAIL sat_stall4_direct got=0x%0h want=0xf", stall_cnt4);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        expect_now(K_CYC, 64'd0, "clr_cyc");
        expect_now(K_STALL, 64'd0, "clr_stall");
        expect_now(K_REDIR, 64'd0, "clr_redir");
        expect_now(K_STALL4, 64'd0, "clr_stall4");
        checks = checks + 1;
        if (cyc_cnt !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL clr_cyc_direct got=0x%0h want=0", cyc_cnt);
        end
        checks = checks + 1;
        if (redir_cnt !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL clr_redir_direct got=0x%0h want=0", redir_cnt);
        end

        // Reset in FLUSH_WAIT, colliding with another redirect.
        stage_fin      = 5'b10111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        expect_next(K_FP, 64'h1, "rstfw_enter");
        tick();
        rst         = 1'b1;
        redirect_pc = 32'h500;
        expect_now(K_FLUSH, 64'h1e, "rstfw_flush");
        expect_next(K_PC, 64'h0, "rstfw_pc");
        expect_next(K_FP, 64'h0, "rstfw_fp");
        expect_next(K_REDIR, 64'd0, "rstfw_redir");
        expect_next(K_CYC, 64'd0, "rstfw_cyc");
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        stage_fin      = 5'h1f;
        expect_now(K_EN, 64'h1f, "post_rst_en");
        expect_next(K_PC, 64'h4, "post_rst_pc");
        tick();
        tick();
        @(negedge clk);
        #1;

        foreach (sb[k]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s unchecked cyc=%0d want=0x%0h", sb[k].name, sb[k].cyc, sb[k].val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
